// File: rtl/ram_bist_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : ram_bist_ctrl                                                 |
// | Description : March C- style BIST sequencer (W0, R0W1^, R1W0v, R0^) for a   |
// |               40-bit RAM with 1-cycle read latency. Optional first-failure  |
// |               capture is enabled by defining RAM_BIST_DIAG_EN.              |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module ram_bist_ctrl #(
  parameter int          ADDR_W = 9,
  parameter logic [39:0] BG     = 40'hAAAAA_55555
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [1:0]  port_sel_i,
  input  logic [39:0] rddata_i,
  output logic        bist_active_a_o,
  output logic        bist_active_b_o,
  output logic        bist_en_o,
  output logic        bist_we_o,
  output logic        bist_re_o,
  output logic [15:0] bist_addr_o,
  output logic [39:0] bist_wrdata_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        fail_o,
  output logic [15:0] fail_addr_o,
  output logic [39:0] fail_bits_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_W0    = 3'd1;
  localparam logic [2:0] S_R0W1  = 3'd2;
  localparam logic [2:0] S_R1W0  = 3'd3;
  localparam logic [2:0] S_R0    = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              phase_q, phase_d;
  logic [1:0]        sel_q, sel_d;
  logic              fail_q, fail_d;
  logic              cmp_vld_q, cmp_vld_d;
  logic              cmp_inv_q, cmp_inv_d;

  logic start_ok;
  logic mismatch;
  logic we, re;

  assign start_ok = ((state_q == S_IDLE) || (state_q == S_DONE)) &&
                    start_i && (port_sel_i != 2'b00);
  // Read data returns one cycle after the read strobe; compare against the
  // background that was expected at that read.
  assign mismatch = cmp_vld_q && (rddata_i != (cmp_inv_q ? ~BG : BG));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      phase_q   <= 1'b0;
      sel_q     <= 2'b00;
      fail_q    <= 1'b0;
      cmp_vld_q <= 1'b0;
      cmp_inv_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      phase_q   <= phase_d;
      sel_q     <= sel_d;
      fail_q    <= fail_d;
      cmp_vld_q <= cmp_vld_d;
      cmp_inv_q <= cmp_inv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    phase_d = phase_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          state_d = S_W0;
          addr_d  = '0;
          phase_d = 1'b0;
        end
      end
      S_W0: begin
        addr_d = addr_q + ADDR_ONE;
        if (addr_q == ADDR_MAX) state_d = S_R0W1;
      end
      S_R0W1: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          addr_d = addr_q + ADDR_ONE;
          if (addr_q == ADDR_MAX) begin
            state_d = S_R1W0;
            addr_d  = ADDR_MAX;
          end
        end
      end
      S_R1W0: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          addr_d = addr_q - ADDR_ONE;
          if (addr_q == '0) begin
            state_d = S_R0;
            addr_d  = '0;
          end
        end
      end
      S_R0: begin
        addr_d = addr_q + ADDR_ONE;
        if (addr_q == ADDR_MAX) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    we            = 1'b0;
    re            = 1'b0;
    bist_wrdata_o = '0;
    case (state_q)
      S_W0: begin
        we            = 1'b1;
        bist_wrdata_o = BG;
      end
      S_R0W1: begin
        we            = phase_q;
        re            = ~phase_q;
        bist_wrdata_o = phase_q ? ~BG : '0;
      end
      S_R1W0: begin
        we            = phase_q;
        re            = ~phase_q;
        bist_wrdata_o = phase_q ? BG : '0;
      end
      S_R0:    re = 1'b1;
      default: ;
    endcase
    busy_o          = (state_q != S_IDLE) && (state_q != S_DONE);
    done_o          = (state_q == S_DONE);
    bist_we_o       = we;
    bist_re_o       = re;
    bist_en_o       = we | re;
    bist_addr_o     = (we | re) ? 16'(addr_q) : 16'h0;
    bist_active_a_o = busy_o & sel_q[0];
    bist_active_b_o = busy_o & sel_q[1];
  end

  always_comb begin
    sel_d     = start_ok ? port_sel_i : sel_q;
    fail_d    = start_ok ? 1'b0 : (fail_q | mismatch);
    cmp_vld_d = re;
    cmp_inv_d = (state_q == S_R1W0);
  end

  assign fail_o = fail_q;

`ifdef RAM_BIST_DIAG_EN
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
  logic [15:0]       fail_addr_q, fail_addr_d;
  logic [39:0]       fail_bits_q, fail_bits_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cmp_addr_q  <= '0;
      fail_addr_q <= '0;
      fail_bits_q <= '0;
    end else begin
      cmp_addr_q  <= cmp_addr_d;
      fail_addr_q <= fail_addr_d;
      fail_bits_q <= fail_bits_d;
    end
  end

  // Only the first mismatch of a run is kept; fail_q marks it as taken.
  always_comb begin
    cmp_addr_d  = addr_q;
    fail_addr_d = fail_addr_q;
    fail_bits_d = fail_bits_q;
    if (start_ok) begin
      fail_addr_d = '0;
      fail_bits_d = '0;
    end else if (mismatch && !fail_q) begin
      fail_addr_d = 16'(cmp_addr_q);
      fail_bits_d = rddata_i ^ (cmp_inv_q ? ~BG : BG);
    end
  end

  assign fail_addr_o = fail_addr_q;
  assign fail_bits_o = fail_bits_q;
`else
  assign fail_addr_o = 16'h0;
  assign fail_bits_o = 40'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_bist_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_ram_bist_ctrl                                              |
// | Description : Bench for ram_bist_ctrl: faulty-RAM model plus march model.   |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_ram_bist_ctrl;

  localparam int          AW = 2;
  localparam int          N  = 4;
  localparam logic [39:0] BG = 40'hAAAAA_55555;
`ifdef RAM_BIST_DIAG_EN
  localparam bit DIAG = 1'b1;
`else
  localparam bit DIAG = 1'b0;
`endif

  typedef struct {
    logic        busy, we, re, aa, ab, done, fail;
    logic [15:0] addr, fa;
    logic [39:0] wd, fb;
  } cyc_t;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [1:0]  sel = 2'b00;
  logic [39:0] rddata = '0;
  logic        aa, ab, en, we, re, busy, done, fail;
  logic [15:0] addr, fa;
  logic [39:0] wd, fb;

  logic [39:0] mem [N];
  logic [39:0] s0 [N];
  logic [39:0] s1 [N];

  cyc_t        expq[$];
  cyc_t        idle_e;
  bit          chk_en = 1'b0;
  int          checks = 0, errors = 0;
  logic [15:0] rec_addr [32];
  logic [39:0] rec_wd [32];
  int          exp_r1w0 [8] = '{3, 3, 2, 2, 1, 1, 0, 0};

  always #5 clk = ~clk;

  ram_bist_ctrl #(.ADDR_W(AW), .BG(BG)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .port_sel_i(sel),
    .rddata_i(rddata), .bist_active_a_o(aa), .bist_active_b_o(ab),
    .bist_en_o(en), .bist_we_o(we), .bist_re_o(re), .bist_addr_o(addr),
    .bist_wrdata_o(wd), .busy_o(busy), .done_o(done), .fail_o(fail),
    .fail_addr_o(fa), .fail_bits_o(fb)
  );

  // RAM with stuck-at masks applied on the read path, 1-cycle latency
  always @(posedge clk) begin
    if (we) mem[addr[AW-1:0]] <= wd;
    if (re) rddata <= (mem[addr[AW-1:0]] | s1[addr[AW-1:0]]) & ~s0[addr[AW-1:0]];
  end

  function automatic cyc_t zero_e();
    cyc_t e;
    e.busy = 0; e.we = 0; e.re = 0; e.aa = 0; e.ab = 0; e.done = 0; e.fail = 0;
    e.addr = '0; e.fa = '0; e.wd = '0; e.fb = '0;
    return e;
  endfunction

  function automatic cyc_t busy_e(input logic [1:0] s);
    cyc_t e;
    e = zero_e();
    e.busy = 1; e.aa = s[0]; e.ab = s[1];
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, got, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " flags"}, 64'({busy, we, re, en, aa, ab, done, fail}), 64'h0);
    chk({nm, " addr"}, 64'(addr), 64'h0);
    chk({nm, " wrdata"}, 64'(wd), 64'h0);
    chk({nm, " fail_addr"}, 64'(fa), 64'h0);
    chk({nm, " fail_bits"}, 64'(fb), 64'h0);
  endtask

  // Expected cycle-by-cycle trace of one whole march from the element list
  task automatic build(input logic [1:0] s);
    cyc_t        q[$];
    cyc_t        e;
    logic [39:0] m [N];
    logic [39:0] ex, got, fbt;
    logic [15:0] fad;
    int          first, a;
    first = -1; fad = '0; fbt = '0;
    for (int el = 0; el < 4; el++) begin
      for (int k = 0; k < N; k++) begin
        a = (el == 2) ? N - 1 - k : k;
        if (el != 0) begin
          ex  = (el == 2) ? ~BG : BG;
          got = (m[a] | s1[a]) & ~s0[a];
          if (got !== ex && first < 0) begin
            first = q.size(); fad = 16'(a); fbt = got ^ ex;
          end
          e = busy_e(s); e.re = 1; e.addr = 16'(a);
          q.push_back(e);
        end
        if (el != 3) begin
          m[a] = (el == 1) ? ~BG : BG;
          e = busy_e(s); e.we = 1; e.addr = 16'(a); e.wd = m[a];
          q.push_back(e);
        end
      end
    end
    q.push_back(busy_e(s));
    foreach (q[i]) begin
      if (first >= 0 && i >= first + 2) begin
        q[i].fail = 1;
        q[i].fa = DIAG ? fad : 16'h0;
        q[i].fb = DIAG ? fbt : 40'h0;
      end
    end
    idle_e = zero_e();
    idle_e.done = 1;
    idle_e.fail = (first >= 0);
    idle_e.fa = (DIAG && first >= 0) ? fad : 16'h0;
    idle_e.fb = (DIAG && first >= 0) ? fbt : 40'h0;
    foreach (q[i]) expq.push_back(q[i]);
  endtask

  initial begin
    cyc_t e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e = (expq.size() > 0) ? expq.pop_front() : idle_e;
        checks++;
        if ({busy, we, re, en, aa, ab, done, fail} !==
              {e.busy, e.we, e.re, e.we | e.re, e.aa, e.ab, e.done, e.fail} ||
            addr !== e.addr || wd !== e.wd || fa !== e.fa || fb !== e.fb) begin
          errors++;
          $display("FAIL cycle t=%0t: busy/we/re/en/aa/ab/done/fail=%b addr=%h wd=%h fa=%h fb=%h, required %b addr=%h wd=%h fa=%h fb=%h",
                   $time, {busy, we, re, en, aa, ab, done, fail}, addr, wd, fa, fb,
                   {e.busy, e.we, e.re, e.we | e.re, e.aa, e.ab, e.done, e.fail},
                   e.addr, e.wd, e.fa, e.fb);
        end
      end
    end
  end

  task automatic do_start(input logic [1:0] s);
    @(posedge clk); #1; start = 1'b1; sel = s;
    @(posedge clk); #1; start = 1'b0; sel = 2'($urandom);
    if (s != 2'b00) build(s);
  endtask

  task automatic wait_done(input int pulse_at, input int rst_at, output int nbusy, output bit hit_rst);
    nbusy = 0; hit_rst = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (busy) begin
        if (nbusy < 32) begin rec_addr[nbusy] = addr; rec_wd[nbusy] = wd; end
        nbusy++;
      end
      start = 1'b0;
      if (busy && nbusy == pulse_at) begin
        start = 1'b1; sel = 2'($urandom_range(1, 3));
      end
      if (busy && nbusy == rst_at) begin
        #2;
        start = 1'b0; rst_n = 1'b0;
        expq.delete();
        idle_e = zero_e();
        #1;
        chk_zero("async reset");
        hit_rst = 1;
        return;
      end
      if (done) return;
    end
    chk("march timeout done_o", 64'(done), 64'h1);
  endtask

  initial begin
    int nb;
    bit hr;
    for (int i = 0; i < N; i++) begin s0[i] = '0; s1[i] = '0; mem[i] = '0; end
    idle_e = zero_e();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    chk_en = 1'b1;

    // start with no port selected is ignored
    do_start(2'b00);
    repeat (3) @(negedge clk);
    chk("sel00 busy", 64'(busy), 64'h0);
    chk("sel00 done", 64'(done), 64'h0);

    // clean run on port A
    do_start(2'b01);
    wait_done(0, 0, nb, hr);
    chk("clean busy cycles", 64'(nb), 64'd25);
    chk("clean done", 64'(done), 64'h1);
    chk("clean fail", 64'(fail), 64'h0);
    chk("W0 wrdata", 64'(rec_wd[0]), 64'h00_AAAAA_55555);
    chk("R0W1 wrdata", 64'(rec_wd[5]), 64'h00_55555_AAAAA);
    for (int k = 0; k < 8; k++)
      chk("R1W0 addr", 64'(rec_addr[12 + k]), 64'(exp_r1w0[k]));
    for (int k = 1; k < 8; k += 2)
      chk("R1W0 wrdata", 64'(rec_wd[12 + k]), 64'h00_AAAAA_55555);

    // bit 7 of address 2 stuck at 1
    s1[2] = 40'h80;
    do_start(2'b01);
    wait_done(0, 0, nb, hr);
    chk("stuck fail", 64'(fail), 64'h1);
    chk("stuck fail_addr", 64'(fa), DIAG ? 64'h2 : 64'h0);
    chk("stuck fail_bits", 64'(fb), DIAG ? 64'h80 : 64'h0);
    s1[2] = '0;

    // start pulsed in the 5th busy cycle is ignored
    do_start(2'b11);
    wait_done(5, 0, nb, hr);
    chk("ignored start busy cycles", 64'(nb), 64'd25);
    chk("ignored start fail", 64'(fail), 64'h0);

    // reset during R1W0, then a fresh full march
    do_start(2'b10);
    wait_done(0, 15, nb, hr);
    chk("reset hit", 64'(hr), 64'h1);
    @(posedge clk); #1; rst_n = 1'b1;
    do_start(2'b10);
    wait_done(0, 0, nb, hr);
    chk("post-reset busy cycles", 64'(nb), 64'd25);
    chk("post-reset done", 64'(done), 64'h1);

    for (int r = 0; r < 24; r++) begin
      int pa, ra, fad, fbit;
      for (int i = 0; i < N; i++) begin s0[i] = '0; s1[i] = '0; end
      if ($urandom_range(0, 1) == 1) begin
        fad  = int'($urandom_range(0, N - 1));
        fbit = int'($urandom_range(0, 39));
        if ($urandom_range(0, 1) == 1) s1[fad][fbit] = 1'b1;
        else                           s0[fad][fbit] = 1'b1;
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      if ($urandom_range(0, 3) == 0) do_start(2'b00);
      pa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 24)) : 0;
      ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 24)) : 0;
      do_start(2'($urandom_range(1, 3)));
      wait_done(pa, ra, nb, hr);
      if (hr) begin
        @(posedge clk); #1; rst_n = 1'b1;
      end else begin
        chk("random busy cycles", 64'(nb), 64'(6 * N + 1));
      end
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_bist_ctrl.md
RAM_BIST_CTRL -- requirements
Module: ram_bist_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, giving the address counter width (depth N = 2^ADDR_W, max 16).
REQ-002 SHALL have parameter BG, default 40'hAAAAA_55555, giving data background "0"; background "1" is ~BG.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n_i, input, 1, the reset; it is asynchronous and active-low.
REQ-005 SHALL have port start_i, input, 1, single-cycle request to run the march.
REQ-006 SHALL have port port_sel_i, input, 2, port select: bit0 = port A, bit1 = port B.
REQ-007 SHALL have port rddata_i, input, 40, read data returned from the RAM macros.
REQ-008 SHALL have port bist_active_a_o, input-side companion output, 1, marks BIST ownership of port A.
REQ-009 SHALL have port bist_active_b_o, output, 1, marks BIST ownership of port B.
REQ-010 SHALL have port bist_en_o / bist_we_o / bist_re_o, output, 1 each, RAM enable / write / read strobes.
REQ-011 SHALL have port bist_addr_o, output, 16, word address; bits above ADDR_W are zero.
REQ-012 SHALL have port bist_wrdata_o, output, 40, write data.
REQ-013 SHALL have port busy_o / done_o / fail_o, output, 1 each, status flags.
REQ-014 SHALL have port fail_addr_o, output, 16, and fail_bits_o, output, 40, diagnostic capture.

Function
REQ-015 SHALL implement the FSM IDLE -> W0 -> R0W1 -> R1W0 -> R0 -> DRAIN -> DONE.
REQ-016 SHALL run the elements as follows: W0 ascending (write "0"), R0W1 ascending, R1W0 descending, R0 ascending.
REQ-017 SHALL leave IDLE or DONE only on start_i=1 with port_sel_i != 0; it latches port_sel_i, clears done_o and fail_o, and zeroes the address counter (R1W0 loads N-1).
REQ-018 SHALL ignore start_i while busy_o=1, and SHALL ignore start_i when port_sel_i = 0.
REQ-019 SHALL spend 1 cycle per address in W0 and R0.
REQ-020 SHALL spend 2 cycles per address in R0W1 and R1W0: a read cycle (re=1) followed by a write cycle (we=1) to the same address.
REQ-021 SHALL use a read latency of exactly 1 cycle: rddata_i is compared with the expected value in the cycle after each read.
REQ-022 SHALL insert one DRAIN cycle, used only to compare the last R0 read, so the total busy time is 6N+1 cycles.
REQ-023 SHALL drive bist_en_o high exactly when we or re is high.
REQ-024 SHALL drive bist_wrdata_o to the current write background during writes and 0 otherwise.
REQ-025 SHALL change element when the address counter wraps (N-1 -> 0 ascending, 0 -> N-1 descending); no element is ever cut short.
REQ-026 SHALL hold bist_active_a_o = latched bit0 and bist_active_b_o = latched bit1 while busy, and 0 otherwise.
REQ-027 SHALL set fail_o sticky on any compare mismatch; the march still runs to completion.
REQ-028 SHALL assert done_o in DONE and hold it until the next accepted start.
REQ-029 SHALL assert busy_o in every state except IDLE and DONE.

Reset
REQ-030 SHALL, on rst_n_i=0 (including mid-march), immediately put the FSM in IDLE and drive every output, counter and flag to 0.
REQ-031 SHALL perform no RAM access until a start_i is accepted after reset release.

Configuration
REQ-032 SHALL, with RAM_BIST_DIAG_EN defined, capture the first mismatch: fail_addr_o = failing address, fail_bits_o = rddata_i XOR expected; both are held until the next accepted start.
REQ-033 SHALL, without RAM_BIST_DIAG_EN, tie fail_addr_o and fail_bits_o to 0 and contain no capture registers; fail_o behaviour is unchanged.

Verification
REQ-034 SHALL pass this scenario: ADDR_W=2, port_sel=01, ideal RAM model -> busy 25 cycles, done_o=1, fail_o=0, bist_active_a_o=1 and bist_active_b_o=0 while busy.
REQ-035 SHALL pass this scenario: ADDR_W=2, bit 7 of address 2 stuck-at-1 -> fail_o=1; with DIAG fail_addr_o=2 and fail_bits_o=40'h80.
REQ-036 SHALL pass this scenario: start_i pulsed in the 5th busy cycle -> ignored, and the run still ends after 25 cycles.
REQ-037 SHALL pass this scenario: rst_n_i low during R1W0 -> all outputs 0 asynchronously, then a fresh start runs a full 25-cycle march.
REQ-038 SHALL pass this scenario: start_i with port_sel_i=00 -> stays IDLE, and busy_o and done_o stay 0.
REQ-039 SHALL pass this scenario: ADDR_W=2 -> the address sequence in R1W0 is 3,3,2,2,1,1,0,0 and wrdata is 40'hAAAAA_55555 in R1W0 writes.
